alu_result_buffer: RTL and testbench

Downstream stage of the 32-bit combinational ALU. It captures result, flags and command into a small FIFO with a valid/ready handshake, so the ALU's producer and the consumer (register writeback / status logic) are decoupled. It normalises flags per command, derives a negative flag, and keeps sticky overflow/carry status bits until software clears them.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_result_fifo_mem.sv | 38 +++
 rtl/alu_result_buffer.sv | 145 ++++++++++++++
 tb/tb_alu_result_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its downstream result buffer:
//   - alu_cmd_e      : 3-bit ALU command encodings
//   - FLAG_*         : bit positions inside the 4-bit flag word
//   - cmd_flags_valid: carry/zero/overflow are meaningful only for ADD/SUB
//   - normalise_flags: builds the stored flag word for a given command
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

    localparam int CMD_W  = 3;
    localparam int FLAG_W = 4;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 3;

    // Arithmetic flags only mean something for the 00x commands (ADD, SUB).
    function automatic logic cmd_flags_valid(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB);
    endfunction

    // Negative always follows the result MSB; the other three flags are
    // forced to zero for commands where the ALU does not define them.
    function automatic logic [FLAG_W-1:0] normalise_flags(
        input logic [CMD_W-1:0] cmd,
        input logic             neg,
        input logic             carry,
        input logic             zero,
        input logic             ovf
    );
        logic [FLAG_W-1:0] f;
        logic              keep;
        keep          = cmd_flags_valid(cmd);
        f             = '0;
        f[FLAG_NEG]   = neg;
        f[FLAG_OVF]   = ovf   & keep;
        f[FLAG_ZERO]  = zero  & keep;
        f[FLAG_CARRY] = carry & keep;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_fifo_mem.sv
// -----------------------------------------------------------------------------
// alu_result_fifo_mem
// Storage array for the ALU result buffer: DEPTH entries of DATA_W bits.
// Ports:
//   clk   in          clock, rising edge
//   we    in          write enable
//   waddr in  ADDR_W  write address
//   wdata in  DATA_W  write data
//   raddr in  ADDR_W  read address
//   rdata out DATA_W  read data (combinational from raddr)
// The data array carries no reset; validity is tracked by the owner.
// -----------------------------------------------------------------------------
module alu_result_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 39,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read is asynchronous so the head entry is visible in the same cycle
    // the registered read pointer moves.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
// Small FIFO between the combinational ALU and its consumer. Captures result,
// normalised flags and command on a valid/ready push, presents the head entry
// on out_*, and keeps sticky overflow/carry bits until sticky_clr.
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   in_valid, in_ready              producer handshake (in_ready = !full)
//   in_result, in_carryout, in_zero,
//   in_overflow, in_command         ALU outputs sampled on a push
//   out_valid, out_ready            consumer handshake (out_valid = !empty)
//   out_result, out_flags,
//   out_command                     head entry ({neg, ovf, zero, carry})
//   sticky_ovf, sticky_carry        accumulated add/sub status
//   sticky_clr                      synchronous clear of both sticky bits
//   count                           occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carryout,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic [2:0]       in_command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [2:0]       out_command,
    output logic             sticky_ovf,
    output logic             sticky_carry,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = WIDTH + FLAG_W + CMD_W;

    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sticky_ovf_q, sticky_ovf_d;
    logic               sticky_carry_q, sticky_carry_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [FLAG_W-1:0]  in_flags;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    // Full/empty come only from the registered count, so a pop cannot make
    // room for a push in the same cycle.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    assign in_flags = normalise_flags(in_command, in_result[WIDTH-1],
                                      in_carryout, in_zero, in_overflow);
    assign wdata    = {in_result, in_flags, in_command};

    always_comb begin
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        count_d        = count_q;
        sticky_ovf_d   = sticky_ovf_q;
        sticky_carry_d = sticky_carry_q;

        // DEPTH is a power of two, so the pointers wrap by truncation.
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear is applied first so a same-cycle set overrides it.
        if (sticky_clr) begin
            sticky_ovf_d   = 1'b0;
            sticky_carry_d = 1'b0;
        end
        if (push && in_flags[FLAG_OVF]) begin
            sticky_ovf_d = 1'b1;
        end
        if (push && in_flags[FLAG_CARRY]) begin
            sticky_carry_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_carry_q <= sticky_carry_d;
        end
    end

    alu_result_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    // The array is not reset, so the head is masked to zero while empty.
    assign {out_result, out_flags, out_command} = empty ? '0 : rdata;

    assign in_ready     = !full;
    assign out_valid    = !empty;
    assign sticky_ovf   = sticky_ovf_q;
    assign sticky_carry = sticky_carry_q;
    assign count        = count_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carryout;
    logic             in_zero;
    logic             in_overflow;
    logic [2:0]       in_command;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [2:0]       out_command;
    logic             sticky_ovf;
    logic             sticky_carry;
    logic             sticky_clr;
    logic [CNT_W-1:0] count;

    int checks   = 0;
    int failures = 0;

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carryout  (in_carryout),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .in_command   (in_command),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .out_command  (out_command),
        .sticky_ovf   (sticky_ovf),
        .sticky_carry (sticky_carry),
        .sticky_clr   (sticky_clr),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
        logic [3:0]  flags;   // expected {neg, ovf, zero, carry}
    } vec_t;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  f;
        logic [2:0]  c;
    } ent_t;

    vec_t vecs [10];
    ent_t mq [$];
    bit   m_sov;
    bit   m_sc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] cmd, input logic [31:0] r,
                          input logic c, input logic z, input logic v);
        in_command  = cmd;
        in_result   = r;
        in_carryout = c;
        in_zero     = z;
        in_overflow = v;
    endtask

    task automatic push_one(input logic [2:0] cmd, input logic [31:0] r,
                            input logic c, input logic z, input logic v);
        set_in(cmd, r, c, z, v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             cmd       result        c     z     v     {n,v,z,c}
        vecs[0] = '{CMD_ADD,  32'h00000000, 1'b1, 1'b1, 1'b0, 4'b0011};
        vecs[1] = '{CMD_SUB,  32'h80000000, 1'b0, 1'b0, 1'b1, 4'b1100};
        vecs[2] = '{CMD_AND,  32'hFFFF0000, 1'b1, 1'b1, 1'b1, 4'b1000};
        vecs[3] = '{CMD_XOR,  32'h12345678, 1'b1, 1'b0, 1'b1, 4'b0000};
        vecs[4] = '{CMD_SLT,  32'h00000001, 1'b1, 1'b1, 1'b1, 4'b0000};
        vecs[5] = '{CMD_NAND, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[6] = '{CMD_NOR,  32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[7] = '{CMD_OR,   32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 4'b1000};
        vecs[8] = '{CMD_ADD,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 4'b1101};
        vecs[9] = '{CMD_SUB,  32'h00000000, 1'b1, 1'b1, 1'b0, 4'b0011};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        set_in(3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_sticky_ovf", 64'(sticky_ovf), 64'd0);
        chk("rst_sticky_carry", 64'(sticky_carry), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        chk("rst_out_command", 64'(out_command), 64'd0);
        rst_n = 1'b1;

        // First push: one-cycle latency, ADD flags kept
        push_one(CMD_ADD, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("first_out_valid", 64'(out_valid), 64'd1);
        chk("first_out_result", 64'(out_result), 64'd0);
        chk("first_out_flags", 64'(out_flags), 64'b0011);
        chk("first_sticky_carry", 64'(sticky_carry), 64'd1);
        chk("first_count", 64'(count), 64'd1);
        pop_one();
        chk("first_pop_count", 64'(count), 64'd0);
        $display("txn first push/pop done");

        // SUB then AND queued together; bogus AND flags dropped
        push_one(CMD_SUB, 32'h80000000, 1'b0, 1'b0, 1'b1);
        push_one(CMD_AND, 32'hFFFF0000, 1'b1, 1'b1, 1'b1);
        chk("subadd_head_flags", 64'(out_flags), 64'b1100);
        chk("subadd_sticky_ovf", 64'(sticky_ovf), 64'd1);
        chk("subadd_count", 64'(count), 64'd2);
        pop_one();
        chk("subadd_second_flags", 64'(out_flags), 64'b1000);
        chk("subadd_second_cmd", 64'(out_command), 64'(CMD_AND));
        pop_one();
        $display("txn sub/and pair done");

        // Table: one push and one pop per vector
        for (int i = 0; i < 10; i++) begin
            push_one(vecs[i].cmd, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v);
            chk($sformatf("vec%0d_result", i), 64'(out_result), 64'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(vecs[i].flags));
            chk($sformatf("vec%0d_cmd", i), 64'(out_command), 64'(vecs[i].cmd));
            pop_one();
            chk($sformatf("vec%0d_count", i), 64'(count), 64'd0);
            $display("txn vec %0d cmd=%0d result=0x%08h flags=%b",
                     i, vecs[i].cmd, vecs[i].res, vecs[i].flags);
        end

        // Fill past full with consumer stalled
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(CMD_ADD, 32'(i + 1), 1'b0, 1'b0, 1'b0);
            chk($sformatf("fill%0d_in_ready", i), 64'(in_ready), 64'd1);
            step();
        end
        set_in(CMD_ADD, 32'd5, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        step();
        chk("full_held_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        chk("full_pop_in_ready", 64'(in_ready), 64'd0);
        chk("drain_1", 64'(out_result), 64'd1);
        step();
        chk("after_pop_in_ready", 64'(in_ready), 64'd1);
        chk("after_pop_count", 64'(count), 64'd3);
        chk("drain_2", 64'(out_result), 64'd2);
        step();
        in_valid = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            chk($sformatf("drain_%0d", i), 64'(out_result), 64'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drained_out_valid", 64'(out_valid), 64'd0);
        chk("drained_count", 64'(count), 64'd0);
        $display("txn full/drain done");

        // Steady stream at count=2 across pointer wrap
        push_one(CMD_XOR, 32'd100, 1'b0, 1'b0, 1'b0);
        push_one(CMD_XOR, 32'd101, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(CMD_XOR, 32'(102 + i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("stream%0d_count", i), 64'(count), 64'd2);
            chk($sformatf("stream%0d_result", i), 64'(out_result), 64'(100 + i));
            step();
        end
        in_valid = 1'b0;
        chk("stream_tail0", 64'(out_result), 64'd110);
        step();
        chk("stream_tail1", 64'(out_result), 64'd111);
        step();
        out_ready = 1'b0;
        chk("stream_empty", 64'(out_valid), 64'd0);
        $display("txn steady stream done");

        // Sticky: set beats clear, clear alone clears
        sticky_clr = 1'b1;
        step();
        chk("clr_sticky_ovf", 64'(sticky_ovf), 64'd0);
        chk("clr_sticky_carry", 64'(sticky_carry), 64'd0);
        set_in(CMD_ADD, 32'h7, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("setwins_sticky_ovf", 64'(sticky_ovf), 64'd1);
        chk("setwins_sticky_carry", 64'(sticky_carry), 64'd0);
        step();
        sticky_clr = 1'b0;
        chk("clr2_sticky_ovf", 64'(sticky_ovf), 64'd0);
        pop_one();
        $display("txn sticky set/clear done");

        // Asynchronous reset mid-cycle at count=3
        push_one(CMD_ADD, 32'd11, 1'b0, 1'b0, 1'b0);
        push_one(CMD_ADD, 32'd12, 1'b0, 1'b0, 1'b0);
        push_one(CMD_ADD, 32'd13, 1'b0, 1'b0, 1'b0);
        chk("pre_arst_count", 64'(count), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_result", 64'(out_result), 64'd0);
        step();
        rst_n = 1'b1;
        push_one(CMD_SUB, 32'h55, 1'b1, 1'b0, 1'b0);
        chk("post_arst_valid", 64'(out_valid), 64'd1);
        chk("post_arst_result", 64'(out_result), 64'h55);
        chk("post_arst_count", 64'(count), 64'd1);
        $display("txn async reset done");

        // Randomised traffic against a queue model
        do_reset();
        mq.delete();
        m_sov = 1'b0;
        m_sc  = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit   do_push;
            bit   do_pop;
            bit   keep;
            ent_t e;
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 1) == 1);
            sticky_clr = ($urandom_range(0, 9) == 0);
            set_in(3'($urandom_range(0, 7)), $urandom(), 1'($urandom()),
                   1'($urandom()), 1'($urandom()));

            chk("rnd_in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("rnd_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("rnd_count", 64'(count), 64'(mq.size()));
            chk("rnd_sticky_ovf", 64'(sticky_ovf), 64'(m_sov));
            chk("rnd_sticky_carry", 64'(sticky_carry), 64'(m_sc));
            if (mq.size() > 0) begin
                chk("rnd_head", {25'd0, out_result, out_flags, out_command}, 64'(mq[0]));
            end else begin
                chk("rnd_empty_head", {25'd0, out_result, out_flags, out_command}, 64'd0);
            end

            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = out_ready && (mq.size() > 0);
            keep    = (in_command <= 3'd1);
            e.r     = in_result;
            e.c     = in_command;
            e.f     = {in_result[31], in_overflow & keep, in_zero & keep, in_carryout & keep};
            if (do_pop) begin
                void'(mq.pop_front());
            end
            if (do_push) begin
                mq.push_back(e);
            end
            if (sticky_clr) begin
                m_sov = 1'b0;
                m_sc  = 1'b0;
            end
            if (do_push && e.f[2]) m_sov = 1'b1;
            if (do_push && e.f[0]) m_sc = 1'b1;
            step();
        end
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        $display("txn random traffic done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
